// File: rtl/jtag_dbg_pkg.sv
// Shared debug-path types: OCI channel encodings and the queued command word layout.
// Default widths match the standard CPU debug configuration (2-bit IR, 38-bit shift register).
package jtag_dbg_pkg;

  localparam int DEF_IR_W = 2;
  localparam int DEF_SR_W = 38;

  typedef enum logic [DEF_IR_W-1:0] {
    CH_OCIMEM    = 2'd0,
    CH_TRACEMEM  = 2'd1,
    CH_BREAK     = 2'd2,
    CH_TRACECTRL = 2'd3
  } ch_e;

  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_SR_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/jtag_cmd_fifo.sv
// Sync FIFO with registered storage and head slot readable with no added latency; push visible next cycle.
// A push into a full FIFO is accepted only when the head is popped in the same cycle; no fall-through.
module jtag_cmd_fifo
  import jtag_dbg_pkg::*;
#(
  parameter int W     = DEF_IR_W + DEF_SR_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_dat_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // Pointers carry one extra lap bit so full and empty are distinguishable.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
  end

endmodule

// File: rtl/jtag_debug_cmd_engine.sv
// System-clock side of JTAG debug: syncs update-DR/IR, queues {ir, sr} commands, strobes a channel on handoff.
// Push SYNC_N+1 edges after vs_udr is first sampled high; consumer backpressures via cmd_ready_i, overflow is sticky.
module jtag_debug_cmd_engine
  import jtag_dbg_pkg::*;
#(
  parameter int IR_W    = DEF_IR_W,
  parameter int SR_W    = DEF_SR_W,
  parameter int ACT_BIT = 37,
  parameter int DEPTH   = 4,
  parameter int SYNC_N  = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     vs_udr_i,
  input  logic                     vs_uir_i,
  input  logic [IR_W-1:0]          ir_in_i,
  input  logic [SR_W-1:0]          sr_i,
  input  logic                     cmd_ready_i,
  input  logic                     ovf_clr_i,
  output logic                     cmd_valid_o,
  output logic [IR_W-1:0]          cmd_ir_o,
  output logic [SR_W-1:0]          jdo_o,
  output logic [2**IR_W-1:0]       take_action_o,
  output logic [2**IR_W-1:0]       take_no_action_o,
  output logic                     ir_update_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int W      = IR_W + SR_W;
  localparam int FILL_W = $clog2(SYNC_N + 1);

  logic [SYNC_N-1:0] udr_sync_q, udr_sync_d, uir_sync_q, uir_sync_d;
  logic              udr_hist_q, udr_hist_d, uir_hist_q, uir_hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              overflow_q, overflow_d;
  logic              filled, udr_edge, uir_edge, fire, full, empty, drop;
  logic [W-1:0]      head_dat;

  assign filled   = (fill_q == FILL_W'(SYNC_N));
  assign udr_edge = udr_sync_q[SYNC_N-1] & ~udr_hist_q;
  assign uir_edge = uir_sync_q[SYNC_N-1] & ~uir_hist_q;

  // Until the chains hold real samples the history reads as high, so a level already
  // high across reset release must go low before it can count as an edge.
  always_comb begin
    udr_sync_d = {udr_sync_q[SYNC_N-2:0], vs_udr_i};
    uir_sync_d = {uir_sync_q[SYNC_N-2:0], vs_uir_i};
    udr_hist_d = filled ? udr_sync_q[SYNC_N-1] : 1'b1;
    uir_hist_d = filled ? uir_sync_q[SYNC_N-1] : 1'b1;
    fill_d     = filled ? fill_q : fill_q + FILL_W'(1);
  end

  assign cmd_valid_o = ~empty;
  assign fire        = cmd_valid_o & cmd_ready_i;
  assign drop        = udr_edge & full & ~fire;
  assign cmd_ir_o    = head_dat[W-1 -: IR_W];
  assign jdo_o       = head_dat[SR_W-1:0];
  assign ir_update_o = uir_edge;
  assign overflow_o  = overflow_q;

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr_i) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;
  end

  always_comb begin
    take_action_o    = '0;
    take_no_action_o = '0;
    if (fire) begin
      if (jdo_o[ACT_BIT]) take_action_o[cmd_ir_o]    = 1'b1;
      else                take_no_action_o[cmd_ir_o] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_hist_q <= 1'b0;
      uir_hist_q <= 1'b0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      udr_sync_q <= udr_sync_d;
      uir_sync_q <= uir_sync_d;
      udr_hist_q <= udr_hist_d;
      uir_hist_q <= uir_hist_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  jtag_cmd_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (udr_edge),
    .push_dat_i ({ir_in_i, sr_i}),
    .pop_i      (fire),
    .head_dat_o (head_dat),
    .empty_o    (empty),
    .full_o     (full),
    .level_o    (level_o)
  );

endmodule
